// File: rtl/sponge_state_buffer.sv
// Lane-state buffer for the sponge permutation path: CPU byte-strobed write/XOR-absorb and
// random read, plus a go/valid/ready/response exchange of the lower LANES words with the core.
module sponge_state_buffer #(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned LANES     = 25,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic                       wr_xor,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic [DATA_BITS/8-1:0]     wr_strb,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_BITS-1:0]       rd_data,
  input  logic                       clr,
  input  logic                       go,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err,
  output logic                       perm_valid,
  input  logic                       perm_ready,
  output logic [LANES*DATA_BITS-1:0] perm_state_o,
  input  logic                       perm_rsp_valid,
  input  logic [LANES*DATA_BITS-1:0] perm_state_i
);

  localparam int unsigned StrbW = DATA_BITS / 8;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;
  logic [DATA_BITS-1:0] mask;
  logic                 wr_ok;
  logic                 rd_ok;

  // Address range checks collapse to constants when DEPTH fills the address space.
  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_part_range
    assign wr_ok = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_ok = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < StrbW; i++) begin
      mask[i*8 +: 8] = {8{wr_strb[i]}};
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    mem_d    = mem_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          mem_d = '{default: '0};
        end else if (wr_en && wr_ok) begin
          if (wr_xor) begin
            mem_d[wr_addr] = mem_q[wr_addr] ^ (wr_data & mask);
          end else begin
            mem_d[wr_addr] = (mem_q[wr_addr] & ~mask) | (wr_data & mask);
          end
        end
        if (wr_en && !wr_ok) wr_err_d = 1'b1;
        if (go) state_d = StReq;
      end
      StReq: begin
        if (wr_en || clr) wr_err_d = 1'b1;
        if (perm_ready) state_d = StWait;
      end
      StWait: begin
        if (wr_en || clr) wr_err_d = 1'b1;
        if (perm_rsp_valid) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            mem_d[k[ADDR_W-1:0]] = perm_state_i[k*DATA_BITS +: DATA_BITS];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      mem_q    <= '{default: '0};
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign perm_state_o[k*DATA_BITS +: DATA_BITS] = mem_q[k];
  end

  assign rd_data    = rd_ok ? mem_q[rd_addr] : '0;
  assign busy       = (state_q != StIdle);
  assign perm_valid = (state_q == StReq);
  assign done       = done_q;
  assign wr_err     = wr_err_q;

endmodule
